// File: rtl/feeder_pkg.sv
// rtl/feeder_pkg.sv - shared defaults, FSM encoding and lane-slice macro for the skew feeder
`ifndef FEEDER_LANE
`define FEEDER_LANE(idx, w) ((idx)*(w)) +: (w)
`endif

package feeder_pkg;

  localparam int LANES_DEF  = 8;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Tick counter must reach LANES+DEPTH without wrapping.
  function automatic int tick_width(input int lanes, input int depth);
    return $clog2(lanes + depth + 1);
  endfunction

endpackage

// File: rtl/feeder_lane.sv
// rtl/feeder_lane.sv - one skewed lane: registered activation/weight element and sticky done
module feeder_lane
  import feeder_pkg::*;
#(
  parameter int I      = 0,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int TW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic              run,
  input  logic [TW-1:0]     t,
  input  logic [DATA_W-1:0] row_act [DEPTH],
  input  logic [DATA_W-1:0] row_wgt [DEPTH],
  output logic [DATA_W-1:0] act,
  output logic [DATA_W-1:0] wgt,
  output logic              done
);

  localparam int              KW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TW-1:0]   LO      = TW'(I);
  localparam logic [TW-1:0]   DONE_T  = TW'(I + DEPTH);
  localparam logic [TW-1:0]   DEPTH_T = TW'(DEPTH);

  logic [TW-1:0] k;
  logic [KW-1:0] kidx;
  logic          in_win;

  // Before the lane's start tick, t-I wraps to a value well above DEPTH,
  // so one unsigned compare covers both window bounds.
  assign k      = t - LO;
  assign kidx   = k[KW-1:0];
  assign in_win = (k < DEPTH_T);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act  <= '0;
      wgt  <= '0;
      done <= 1'b0;
    end else if (en) begin
      if (clear) begin
        act  <= '0;
        wgt  <= '0;
        done <= 1'b0;
      end else if (run) begin
        if (in_win) begin
          act <= row_act[kidx];
          wgt <= row_wgt[kidx];
        end else begin
          act <= '0;
          wgt <= '0;
        end
        if (t == DONE_T) begin
          done <= 1'b1;
        end
      end else begin
        act <= '0;
        wgt <= '0;
      end
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - buffers one pass of rows and streams them as a skewed wavefront
// Optional pass counter output enabled by FEEDER_PASS_CNT_EN.
module systolic_skew_feeder
  import feeder_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_act,
  input  logic [DATA_W-1:0]       wr_wgt,
  input  logic                    start,
  input  logic                    cluster_done,
  output logic [LANES*DATA_W-1:0] activations,
  output logic [LANES*DATA_W-1:0] weights,
  output logic [LANES-1:0]        done,
  output logic                    busy,
  output logic                    pass_done
`ifdef FEEDER_PASS_CNT_EN
  ,
  output logic [15:0]             pass_count
`endif
);

  localparam int            ENTRIES = LANES * DEPTH;
  localparam int            TW      = tick_width(LANES, DEPTH);
  localparam logic [TW-1:0] LAST_T  = TW'(LANES - 1 + DEPTH);

  logic [DATA_W-1:0] act_buf [ENTRIES];
  logic [DATA_W-1:0] wgt_buf [ENTRIES];

  state_t        state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic          busy_q, busy_d;
  logic          pass_done_q, pass_done_d;
  logic          start_pass;
  logic          run;
  logic          wr_ok;

  // Rows only change between passes; out-of-range entries are dropped.
  assign wr_ok = en && wr_en && (state_q == IDLE) &&
                 ({1'b0, wr_addr} < (ADDR_W + 1)'(ENTRIES));

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      act_buf[wr_addr] <= wr_act;
      wgt_buf[wr_addr] <= wr_wgt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      t_q         <= '0;
      busy_q      <= 1'b0;
      pass_done_q <= 1'b0;
    end else if (en) begin
      state_q     <= state_d;
      t_q         <= t_d;
      busy_q      <= busy_d;
      pass_done_q <= pass_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    busy_d      = busy_q;
    pass_done_d = 1'b0;
    start_pass  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          t_d        = '0;
          busy_d     = 1'b1;
          start_pass = 1'b1;
        end
      end
      RUN: begin
        t_d = t_q + 1'b1;
        if (t_q == LAST_T) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cluster_done) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          pass_done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign run       = (state_q == RUN);
  assign busy      = busy_q;
  assign pass_done = pass_done_q;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [DATA_W-1:0] row_act [DEPTH];
    logic [DATA_W-1:0] row_wgt [DEPTH];

    for (genvar gk = 0; gk < DEPTH; gk++) begin : g_elem
      assign row_act[gk] = act_buf[gi*DEPTH + gk];
      assign row_wgt[gk] = wgt_buf[gi*DEPTH + gk];
    end

    feeder_lane #(
      .I      (gi),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .TW     (TW)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .clear   (start_pass),
      .run     (run),
      .t       (t_q),
      .row_act (row_act),
      .row_wgt (row_wgt),
      .act     (activations[`FEEDER_LANE(gi, DATA_W)]),
      .wgt     (weights[`FEEDER_LANE(gi, DATA_W)]),
      .done    (done[gi])
    );
  end

`ifdef FEEDER_PASS_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_count <= '0;
    end else if (en && pass_done_d) begin
      pass_count <= pass_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - directed-vector bench for systolic_skew_feeder
module tb_systolic_skew_feeder;

  localparam int LANES  = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;
  localparam int BW     = LANES * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_act;
  logic [DATA_W-1:0] wr_wgt;
  logic              start;
  logic              cluster_done;
  logic [BW-1:0]     activations;
  logic [BW-1:0]     weights;
  logic [LANES-1:0]  done;
  logic              busy;
  logic              pass_done;
`ifdef FEEDER_PASS_CNT_EN
  logic [15:0]       pass_count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  systolic_skew_feeder #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_act       (wr_act),
    .wr_wgt       (wr_wgt),
    .start        (start),
    .cluster_done (cluster_done),
    .activations  (activations),
    .weights      (weights),
    .done         (done),
    .busy         (busy),
    .pass_done    (pass_done)
`ifdef FEEDER_PASS_CNT_EN
    ,
    .pass_count   (pass_count)
`endif
  );

  always #5 clk = ~clk;

  // Output cycle c (c=1 is the cycle after start): lane i element k at c=1+i+k,
  // with act[n]=n+1 and wgt[n]=0x100+n for n=i*DEPTH+k.
  function automatic logic [BW-1:0] exp_bus(input int c, input bit is_wgt);
    logic [BW-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) begin
      int k;
      k = c - 1 - i;
      if (k >= 0 && k < DEPTH) begin
        if (is_wgt) v[i*DATA_W +: DATA_W] = 16'(32'h100 + i*DEPTH + k);
        else        v[i*DATA_W +: DATA_W] = 16'(i*DEPTH + k + 1);
      end
    end
    return v;
  endfunction

  function automatic logic [LANES-1:0] exp_done(input int c);
    logic [LANES-1:0] d;
    for (int i = 0; i < LANES; i++) d[i] = (c >= 1 + i + DEPTH);
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_pass();
    cluster_done = 1'b1;
    tick();
    cluster_done = 1'b0;
    tick();
  endtask

  task automatic load_buffers();
    for (int n = 0; n < LANES*DEPTH; n++) begin
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(n);
      wr_act  = 16'(n + 1);
      wr_wgt  = 16'(32'h100 + n);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors += 5;
    if (activations !== '0) begin miscompares++; $display("FAIL reset_act: got %h expected 0", activations); end
    if (weights !== '0)     begin miscompares++; $display("FAIL reset_wgt: got %h expected 0", weights); end
    if (done !== '0)        begin miscompares++; $display("FAIL reset_done: got %h expected 00", done); end
    if (busy !== 1'b0)      begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (pass_done !== 1'b0) begin miscompares++; $display("FAIL reset_pass_done: got %b expected 0", pass_done); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    load_buffers();
    pulse_start();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL stream_busy_start: got %b expected 1", busy); end
    for (int c = 1; c <= LANES + DEPTH; c++) begin
      tick();
      vectors += 4;
      if (activations !== exp_bus(c, 0)) begin miscompares++; $display("FAIL stream_act c=%0d: got %h expected %h", c, activations, exp_bus(c, 0)); end
      if (weights !== exp_bus(c, 1))     begin miscompares++; $display("FAIL stream_wgt c=%0d: got %h expected %h", c, weights, exp_bus(c, 1)); end
      if (done !== exp_done(c))          begin miscompares++; $display("FAIL stream_done c=%0d: got %h expected %h", c, done, exp_done(c)); end
      if (busy !== 1'b1)                 begin miscompares++; $display("FAIL stream_busy c=%0d: got %b expected 1", c, busy); end
    end
  endtask

  task automatic test_wait_close();
    cluster_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors += 4;
      if (done !== 8'hFF)     begin miscompares++; $display("FAIL wait_done c=%0d: got %h expected ff", c, done); end
      if (busy !== 1'b1)      begin miscompares++; $display("FAIL wait_busy c=%0d: got %b expected 1", c, busy); end
      if (pass_done !== 1'b0) begin miscompares++; $display("FAIL wait_pass_done c=%0d: got %b expected 0", c, pass_done); end
      if (activations !== '0) begin miscompares++; $display("FAIL wait_act c=%0d: got %h expected 0", c, activations); end
    end
    cluster_done = 1'b1;
    tick();
    cluster_done = 1'b0;
    vectors += 3;
    if (pass_done !== 1'b1) begin miscompares++; $display("FAIL close_pulse: got %b expected 1", pass_done); end
    if (busy !== 1'b0)      begin miscompares++; $display("FAIL close_busy: got %b expected 0", busy); end
    if (done !== 8'hFF)     begin miscompares++; $display("FAIL close_done: got %h expected ff", done); end
    tick();
    vectors += 2;
    if (pass_done !== 1'b0) begin miscompares++; $display("FAIL close_pulse_end: got %b expected 0", pass_done); end
    if (done !== 8'hFF)     begin miscompares++; $display("FAIL close_done_hold: got %h expected ff", done); end
  endtask

  task automatic test_enable_stall();
    pulse_start();
    for (int c = 1; c <= LANES + DEPTH; c++) begin
      tick();
      vectors += 3;
      if (activations !== exp_bus(c, 0)) begin miscompares++; $display("FAIL stall_act c=%0d: got %h expected %h", c, activations, exp_bus(c, 0)); end
      if (weights !== exp_bus(c, 1))     begin miscompares++; $display("FAIL stall_wgt c=%0d: got %h expected %h", c, weights, exp_bus(c, 1)); end
      if (done !== exp_done(c))          begin miscompares++; $display("FAIL stall_done c=%0d: got %h expected %h", c, done, exp_done(c)); end
      if (c == 5) begin
        en = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          vectors += 4;
          if (activations !== exp_bus(5, 0)) begin miscompares++; $display("FAIL frozen_act s=%0d: got %h expected %h", s, activations, exp_bus(5, 0)); end
          if (weights !== exp_bus(5, 1))     begin miscompares++; $display("FAIL frozen_wgt s=%0d: got %h expected %h", s, weights, exp_bus(5, 1)); end
          if (done !== exp_done(5))          begin miscompares++; $display("FAIL frozen_done s=%0d: got %h expected %h", s, done, exp_done(5)); end
          if (busy !== 1'b1)                 begin miscompares++; $display("FAIL frozen_busy s=%0d: got %b expected 1", s, busy); end
        end
        en = 1'b1;
      end
    end
    finish_pass();
  endtask

  task automatic test_busy_ignore();
    pulse_start();
    for (int c = 1; c <= LANES + DEPTH; c++) begin
      tick();
      vectors += 2;
      if (activations !== exp_bus(c, 0)) begin miscompares++; $display("FAIL ignore_act c=%0d: got %h expected %h", c, activations, exp_bus(c, 0)); end
      if (done !== exp_done(c))          begin miscompares++; $display("FAIL ignore_done c=%0d: got %h expected %h", c, done, exp_done(c)); end
      if (c == 3) begin
        start        = 1'b1;
        wr_en        = 1'b1;
        wr_addr      = '0;
        wr_act       = 16'hDEAD;
        wr_wgt       = 16'hDEAD;
        cluster_done = 1'b1;
      end else if (c == 4) begin
        start        = 1'b0;
        wr_en        = 1'b0;
        cluster_done = 1'b0;
      end
    end
    tick();
    vectors += 2;
    if (busy !== 1'b1)      begin miscompares++; $display("FAIL ignore_busy_wait: got %b expected 1", busy); end
    if (pass_done !== 1'b0) begin miscompares++; $display("FAIL ignore_no_close: got %b expected 0", pass_done); end
    finish_pass();
  endtask

  task automatic test_reset_mid_pass();
    pulse_start();
    tick();
    vectors += 2;
    if (activations[DATA_W-1:0] !== 16'h0001) begin miscompares++; $display("FAIL buf0_act_kept: got %h expected 0001", activations[DATA_W-1:0]); end
    if (weights[DATA_W-1:0] !== 16'h0100)     begin miscompares++; $display("FAIL buf0_wgt_kept: got %h expected 0100", weights[DATA_W-1:0]); end
    repeat (5) tick();
    vectors++;
    if (activations !== exp_bus(6, 0)) begin miscompares++; $display("FAIL premid_act: got %h expected %h", activations, exp_bus(6, 0)); end
    rst = 1'b1;
    #1;
    vectors += 5;
    if (activations !== '0) begin miscompares++; $display("FAIL async_act: got %h expected 0", activations); end
    if (weights !== '0)     begin miscompares++; $display("FAIL async_wgt: got %h expected 0", weights); end
    if (done !== '0)        begin miscompares++; $display("FAIL async_done: got %h expected 00", done); end
    if (busy !== 1'b0)      begin miscompares++; $display("FAIL async_busy: got %b expected 0", busy); end
    if (pass_done !== 1'b0) begin miscompares++; $display("FAIL async_pass_done: got %b expected 0", pass_done); end
    tick();
    rst = 1'b0;
    tick();
    pulse_start();
    for (int c = 1; c <= LANES + DEPTH; c++) begin
      tick();
      vectors += 3;
      if (activations !== exp_bus(c, 0)) begin miscompares++; $display("FAIL replay_act c=%0d: got %h expected %h", c, activations, exp_bus(c, 0)); end
      if (weights !== exp_bus(c, 1))     begin miscompares++; $display("FAIL replay_wgt c=%0d: got %h expected %h", c, weights, exp_bus(c, 1)); end
      if (done !== exp_done(c))          begin miscompares++; $display("FAIL replay_done c=%0d: got %h expected %h", c, done, exp_done(c)); end
    end
    finish_pass();
  endtask

`ifdef FEEDER_PASS_CNT_EN
  task automatic test_pass_count();
    // The mid-pass reset cleared the counter; only the replay pass closed after it.
    vectors++;
    if (pass_count !== 16'd1) begin miscompares++; $display("FAIL pass_count: got %0d expected 1", pass_count); end
    pulse_start();
    repeat (LANES + DEPTH) tick();
    finish_pass();
    pulse_start();
    repeat (LANES + DEPTH) tick();
    finish_pass();
    vectors++;
    if (pass_count !== 16'd3) begin miscompares++; $display("FAIL pass_count_3: got %0d expected 3", pass_count); end
  endtask
`endif

  initial begin
    rst          = 1'b1;
    en           = 1'b1;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_act       = '0;
    wr_wgt       = '0;
    start        = 1'b0;
    cluster_done = 1'b0;
    test_reset();
    test_stream();
    test_wait_close();
    test_enable_stall();
    test_busy_ignore();
    test_reset_mid_pass();
`ifdef FEEDER_PASS_CNT_EN
    test_pass_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
